// File: rtl/wb_core_arbiter.sv
// Two-master (fetch, LSU) to one-slave Wishbone B4 pipelined arbiter.
// Tracks outstanding strobes per grant and applies bounded-hold preemption.
module wb_core_arbiter #(
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned HOLD_LIMIT      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            m_cyc_i,
    input  logic [1:0]            m_stb_i,
    input  logic [1:0]            m_we_i,
    input  logic [2*AW-1:0]       m_adr_i,
    input  logic [2*DW-1:0]       m_dat_i,
    input  logic [2*(DW/8)-1:0]   m_sel_i,
    output logic [DW-1:0]         m_dat_o,
    output logic [1:0]            m_ack_o,
    output logic [1:0]            m_err_o,
    output logic [1:0]            m_stall_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [(DW/8)-1:0]     s_sel_o,
    input  logic [DW-1:0]         s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_stall_i,
    output logic [1:0]            grant_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned OW = (MAX_OUTSTANDING < 1) ? 1 : $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned HW = (HOLD_LIMIT < 1) ? 1 : $clog2(HOLD_LIMIT + 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_last_owner;
    logic [OW-1:0] r_outstanding;
    logic [HW-1:0] r_hold_cnt;

    logic w_own;
    logic w_idx;
    logic w_other_cyc;
    logic w_full;
    logic w_preempt;
    logic w_gate;
    logic w_live;
    logic w_accept;
    logic w_resp;
    logic w_switch;

    // Owner decode, slave-side mux, gating and response routing
    always_comb begin
        w_own       = (r_state == ST_OWN0) || (r_state == ST_OWN1);
        w_idx       = (r_state == ST_OWN1);
        w_other_cyc = m_cyc_i[~w_idx];
        w_full      = (r_outstanding == OW'(MAX_OUTSTANDING));
        w_preempt   = (HOLD_LIMIT != 0) && w_own && w_other_cyc
                      && (r_hold_cnt >= HW'(HOLD_LIMIT));
        w_gate      = w_full || w_preempt;
        // Responses with nothing outstanding belong to an aborted cycle and are dropped
        w_live      = (r_outstanding != '0);

        s_cyc_o = w_own && m_cyc_i[w_idx];
        s_stb_o = w_own && m_stb_i[w_idx] && !w_gate;
        s_we_o  = m_we_i[w_idx];
        s_adr_o = w_idx ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0];
        s_dat_o = w_idx ? m_dat_i[2*DW-1:DW] : m_dat_i[DW-1:0];
        s_sel_o = w_idx ? m_sel_i[2*SW-1:SW] : m_sel_i[SW-1:0];
        m_dat_o = s_dat_i;

        m_stall_o = m_stb_i;
        m_ack_o   = 2'b00;
        m_err_o   = 2'b00;
        if (w_own) begin
            m_stall_o[w_idx] = s_stall_i || w_gate;
            m_ack_o[w_idx]   = s_ack_i && w_live;
            m_err_o[w_idx]   = s_err_i && w_live;
        end

        w_accept = s_stb_o && !s_stall_i;
        w_resp   = w_own && (s_ack_i || s_err_i) && w_live;
        grant_o  = {r_state == ST_OWN1, r_state == ST_OWN0};
    end

    // Next-state: arbitration in IDLE, handover/preemption out of OWNi
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                case (m_cyc_i)
                    2'b01:   w_state_nxt = ST_OWN0;
                    2'b10:   w_state_nxt = ST_OWN1;
                    2'b11:   w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
            ST_OWN0, ST_OWN1: begin
                if (!m_cyc_i[w_idx]) begin
                    if (w_other_cyc) w_state_nxt = w_idx ? ST_OWN0 : ST_OWN1;
                    else             w_state_nxt = ST_IDLE;
                end else if (w_preempt && !w_live) begin
                    w_state_nxt = w_idx ? ST_OWN0 : ST_OWN1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_switch = (w_state_nxt != r_state);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_own && w_switch) r_last_owner <= w_idx;
        end
    end

    // Outstanding strobes and hold time, both restart on every grant change
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
            r_hold_cnt    <= '0;
        end else if (w_switch) begin
            r_outstanding <= '0;
            r_hold_cnt    <= '0;
        end else begin
            if (w_accept && !w_resp)      r_outstanding <= r_outstanding + OW'(1);
            else if (!w_accept && w_resp) r_outstanding <= r_outstanding - OW'(1);
            if (w_own && (r_hold_cnt < HW'(HOLD_LIMIT))) r_hold_cnt <= r_hold_cnt + HW'(1);
        end
    end

endmodule

// File: tb/tb_wb_core_arbiter.sv
// Bench for wb_core_arbiter: per-cycle behavioural model plus directed scenarios
// with hand-computed expectations (MAX_OUTSTANDING=2, HOLD_LIMIT=8).
module tb_wb_core_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int          MAXO = 2;
    localparam int          HOLD = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [1:0]        m_cyc_i, m_stb_i, m_we_i;
    logic [2*AW-1:0]   m_adr_i;
    logic [2*DW-1:0]   m_dat_i;
    logic [2*SW-1:0]   m_sel_i;
    logic [DW-1:0]     m_dat_o;
    logic [1:0]        m_ack_o, m_err_o, m_stall_o, grant_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_err_i, s_stall_i;

    int n_checks = 0;
    int n_fail   = 0;

    wb_core_arbiter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO), .HOLD_LIMIT(HOLD)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model state: owner -1 = idle, 0 = fetch, 1 = LSU
    int mo = -1, mlast = 0, mout = 0, mhold = 0;

    always @(negedge clk_i) begin : model
        logic [1:0] e_grant, e_ack, e_err, e_stall;
        logic       e_cyc, e_stb;
        int         o, x, nxt, d;
        bit         pre, gate;
        o = 0; x = 1; pre = 0; gate = 0;
        e_grant = 2'b00; e_ack = 2'b00; e_err = 2'b00; e_stall = m_stb_i;
        e_cyc = 1'b0; e_stb = 1'b0;
        if (mo >= 0) begin
            o = mo; x = 1 - mo;
            pre  = (HOLD != 0) && (mhold >= HOLD) && m_cyc_i[x];
            gate = (mout == MAXO) || pre;
            e_grant[o] = 1'b1;
            e_cyc      = m_cyc_i[o];
            e_stb      = m_stb_i[o] && !gate;
            e_stall[o] = s_stall_i || gate;
            e_ack[o]   = s_ack_i && (mout > 0);
            e_err[o]   = s_err_i && (mout > 0);
            chk("m_adr_mux", s_adr_o, m_adr_i[o*AW +: AW]);
            chk("m_dat_mux", s_dat_o, m_dat_i[o*DW +: DW]);
            chk("m_sel_mux", s_sel_o, m_sel_i[o*SW +: SW]);
            chk("m_we_mux",  s_we_o,  m_we_i[o]);
        end
        chk("m_grant", grant_o,   e_grant);
        chk("m_scyc",  s_cyc_o,   e_cyc);
        chk("m_sstb",  s_stb_o,   e_stb);
        chk("m_stall", m_stall_o, e_stall);
        chk("m_ack",   m_ack_o,   e_ack);
        chk("m_err",   m_err_o,   e_err);
        chk("m_rdat",  m_dat_o,   s_dat_i);

        if (rst_i) begin
            mo = -1; mlast = 0; mout = 0; mhold = 0;
        end else begin
            nxt = mo;
            if (mo < 0) begin
                if (m_cyc_i == 2'b01)      nxt = 0;
                else if (m_cyc_i == 2'b10) nxt = 1;
                else if (m_cyc_i == 2'b11) nxt = (mlast == 0) ? 1 : 0;
            end else if (!m_cyc_i[o]) begin
                nxt = m_cyc_i[x] ? x : -1;
            end else if (pre && mout == 0) begin
                nxt = x;
            end
            if (nxt != mo) begin
                if (mo >= 0) mlast = mo;
                mo = nxt; mout = 0; mhold = 0;
            end else if (mo >= 0) begin
                d = 0;
                if (e_stb && !s_stall_i) d = d + 1;
                if ((s_ack_i || s_err_i) && mout > 0) d = d - 1;
                mout = mout + d;
                if (mhold < HOLD) mhold = mhold + 1;
            end
        end
    end

    task automatic nc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_stall_i = 1'b0;
    endtask

    task automatic do_reset();
        nc();
        clear_inputs();
        rst_i = 1'b1;
        nc();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_scyc", s_cyc_o, 1'b0);
        chk("rst_ack", m_ack_o, 2'b00);
        chk("rst_err", m_err_o, 2'b00);
        rst_i = 1'b0;

        // 1: LSU read
        do_reset();
        m_cyc_i = 2'b10; m_stb_i = 2'b10; m_adr_i[AW +: AW] = 32'h8000_0010; #3;
        chk("t1_idle_grant", grant_o, 2'b00);
        chk("t1_idle_stall", m_stall_o, 2'b10);
        nc(); #3;
        chk("t1_grant", grant_o, 2'b10);
        chk("t1_stb", s_stb_o, 1'b1);
        chk("t1_adr", s_adr_o, 32'h8000_0010);
        nc(); m_stb_i = 2'b00; s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; #3;
        chk("t1_ack", m_ack_o, 2'b10);
        chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
        nc(); s_ack_i = 1'b0; m_cyc_i = 2'b00; #3;
        chk("t1_ack_clr", m_ack_o, 2'b00);
        nc(); #3;
        chk("t1_idle_again", grant_o, 2'b00);

        // 2: simultaneous cyc after reset
        do_reset();
        m_cyc_i = 2'b11; #3;
        chk("t2_idle", grant_o, 2'b00);
        nc(); #3;
        chk("t2_lsu_first", grant_o, 2'b10);
        nc(); m_cyc_i = 2'b01; #3;
        chk("t2_lsu_drop_grant", grant_o, 2'b10);
        chk("t2_lsu_drop_cyc", s_cyc_o, 1'b0);
        nc(); #3;
        chk("t2_fetch_next", grant_o, 2'b01);
        nc(); m_cyc_i = 2'b00;

        // 3: outstanding limit of 2
        do_reset();
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[AW-1:0] = 32'h100;
        nc(); #3; chk("t3_s1", s_stb_o, 1'b1);
        nc(); m_adr_i[AW-1:0] = 32'h104; #3; chk("t3_s2", s_stb_o, 1'b1);
        nc(); m_adr_i[AW-1:0] = 32'h108; #3;
        chk("t3_s3_gated", s_stb_o, 1'b0);
        chk("t3_s3_stall", m_stall_o, 2'b01);
        nc(); s_ack_i = 1'b1; #3;
        chk("t3_ack1", m_ack_o, 2'b01);
        chk("t3_still_gated", s_stb_o, 1'b0);
        nc(); s_ack_i = 1'b0; #3;
        chk("t3_s3_issued", s_stb_o, 1'b1);
        chk("t3_s3_adr", s_adr_o, 32'h108);
        nc(); m_stb_i = 2'b00; s_ack_i = 1'b1; #3; chk("t3_ack2", m_ack_o, 2'b01);
        nc(); #3; chk("t3_ack3", m_ack_o, 2'b01);
        nc(); s_ack_i = 1'b0; m_stb_i = 2'b01; m_adr_i[AW-1:0] = 32'h10C; #3;
        chk("t3_empty_a", s_stb_o, 1'b1);
        nc(); m_adr_i[AW-1:0] = 32'h110; #3; chk("t3_empty_b", s_stb_o, 1'b1);
        nc(); #3; chk("t3_full_again", s_stb_o, 1'b0);
        nc(); m_stb_i = 2'b00; m_cyc_i = 2'b00; #3; chk("t3_abort_cyc", s_cyc_o, 1'b0);
        nc(); s_ack_i = 1'b1; #3;
        chk("t3_late_ack", m_ack_o, 2'b00);
        chk("t3_late_grant", grant_o, 2'b00);
        nc(); s_ack_i = 1'b0;

        // 4: hold-limit preemption of a streaming fetch
        do_reset();
        m_cyc_i = 2'b01; m_stb_i = 2'b01; #3;
        chk("t4_idle", grant_o, 2'b00);
        for (int k = 0; k <= 10; k++) begin
            nc();
            m_cyc_i = (k >= 3) ? 2'b11 : 2'b01;
            s_ack_i = (k >= 1 && k <= 8);
            #3;
            if (k < 8) begin
                chk($sformatf("t4_k%0d_stb", k), s_stb_o, 1'b1);
                chk($sformatf("t4_k%0d_stall", k), m_stall_o, 2'b00);
            end else if (k == 8) begin
                chk("t4_k8_stb", s_stb_o, 1'b0);
                chk("t4_k8_stall", m_stall_o, 2'b01);
                chk("t4_k8_ack", m_ack_o, 2'b01);
            end else if (k == 9) begin
                chk("t4_k9_grant", grant_o, 2'b01);
                chk("t4_k9_stall", m_stall_o, 2'b01);
                chk("t4_k9_ack", m_ack_o, 2'b00);
            end else begin
                chk("t4_k10_grant", grant_o, 2'b10);
                chk("t4_k10_ack", m_ack_o, 2'b00);
                chk("t4_k10_stall", m_stall_o, 2'b01);
            end
        end
        nc(); m_cyc_i = 2'b01; #3; chk("t4_lsu_drop", grant_o, 2'b10);
        nc(); #3;
        chk("t4_fetch_back", grant_o, 2'b01);
        chk("t4_fetch_stb", s_stb_o, 1'b1);
        nc(); clear_inputs();

        // 5: slave error on an LSU write
        do_reset();
        m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
        m_adr_i = {32'h4000_0000, 32'h0000_0040};
        m_dat_i = {32'h1234_5678, 32'h0000_AAAA};
        m_sel_i = {4'hF, 4'h3};
        nc(); s_stall_i = 1'b1; #3;
        chk("t5_we", s_we_o, 1'b1);
        chk("t5_wdat", s_dat_o, 32'h1234_5678);
        chk("t5_sel", s_sel_o, 4'hF);
        chk("t5_slave_stall", m_stall_o, 2'b10);
        nc(); s_stall_i = 1'b0; #3; chk("t5_w1", s_stb_o, 1'b1);
        nc(); m_adr_i[AW +: AW] = 32'h4000_0004; #3; chk("t5_w2", s_stb_o, 1'b1);
        nc(); m_adr_i[AW +: AW] = 32'h4000_0008; s_err_i = 1'b1; #3;
        chk("t5_err", m_err_o, 2'b10);
        chk("t5_no_ack", m_ack_o, 2'b00);
        chk("t5_full", s_stb_o, 1'b0);
        nc(); s_err_i = 1'b0; #3; chk("t5_decremented", s_stb_o, 1'b1);
        nc(); m_stb_i = 2'b00; s_ack_i = 1'b1; #3; chk("t5_ack_a", m_ack_o, 2'b10);
        nc(); #3; chk("t5_ack_b", m_ack_o, 2'b10);
        nc(); clear_inputs();

        // 6: reset with two strobes outstanding
        do_reset();
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        nc(); nc();
        nc(); m_stb_i = 2'b00; rst_i = 1'b1; #3;
        chk("t6_pre_rst_grant", grant_o, 2'b01);
        nc(); rst_i = 1'b0; s_ack_i = 1'b1; #3;
        chk("t6_grant", grant_o, 2'b00);
        chk("t6_scyc", s_cyc_o, 1'b0);
        chk("t6_ack", m_ack_o, 2'b00);
        nc(); #3;
        chk("t6_regrant", grant_o, 2'b01);
        chk("t6_ack_dropped", m_ack_o, 2'b00);
        nc(); clear_inputs();
        nc(); nc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
